// File: rtl/fifo_btn_ctrl.sv
// Button front end for the board-level FIFO demo.
// Each button is synchronised, debounced and turned into a one-cycle FIFO strobe.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   btn_wr, btn_rd   raw asynchronous push-buttons
//   full, empty      FIFO status flags
//   push, pop        registered one-cycle FIFO strobes
//   error            sticky flag, set by a rejected request, cleared by an accepted one
//   db_wr, db_rd     debounced button levels

module fifo_btn_db #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic tick
);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            st   <= ZERO;
            cnt  <= '0;
            db   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            tick <= 1'b0;
            unique case (st)
                ZERO: begin
                    cnt <= '0;
                    if (s2) st <= WAIT1;
                end
                WAIT1: begin
                    if (!s2) begin
                        st  <= ZERO;
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        st   <= ONE;
                        cnt  <= '0;
                        db   <= 1'b1;
                        tick <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ONE: begin
                    cnt <= '0;
                    if (!s2) st <= WAIT0;
                end
                WAIT0: begin
                    if (s2) begin
                        st  <= ONE;
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        // release is silent: level drops, no tick
                        st  <= ZERO;
                        cnt <= '0;
                        db  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    st  <= ZERO;
                    cnt <= '0;
                    db  <= 1'b0;
                end
            endcase
        end
    end

endmodule

module fifo_btn_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_wr,
    input  logic btn_rd,
    input  logic full,
    input  logic empty,
    output logic push,
    output logic pop,
    output logic error,
    output logic db_wr,
    output logic db_rd
);

    logic tick_wr;
    logic tick_rd;
    logic rd_ok;
    logic wr_ok;
    logic reject;

    fifo_btn_db #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_wr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_wr),
        .db    (db_wr),
        .tick  (tick_wr)
    );

    fifo_btn_db #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_rd (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_rd),
        .db    (db_rd),
        .tick  (tick_rd)
    );

    // a write at full is fine when a read drains a slot in the same cycle
    assign rd_ok  = tick_rd & ~empty;
    assign wr_ok  = tick_wr & (~full | rd_ok);
    assign reject = (tick_wr & ~wr_ok) | (tick_rd & ~rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            push  <= 1'b0;
            pop   <= 1'b0;
            error <= 1'b0;
        end else begin
            push <= wr_ok;
            pop  <= rd_ok;
            // a rejection wins over an acceptance in the same cycle
            if (reject) begin
                error <= 1'b1;
            end else if (wr_ok | rd_ok) begin
                error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Bench for fifo_btn_ctrl: directed scenarios plus random button traffic.
// A reference model feeds a strobe scoreboard drained by a negedge monitor.

module tb_fifo_btn_ctrl;

    localparam int DB = 16;
    localparam int CW = 21;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_wr = 1'b0;
    logic btn_rd = 1'b0;
    logic full   = 1'b0;
    logic empty  = 1'b0;
    logic push;
    logic pop;
    logic error;
    logic db_wr;
    logic db_rd;

    always #5 clk = ~clk;

    fifo_btn_ctrl #(
        .DB_CYCLES (DB),
        .CNT_W     (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_wr (btn_wr),
        .btn_rd (btn_rd),
        .full   (full),
        .empty  (empty),
        .push   (push),
        .pop    (pop),
        .error  (error),
        .db_wr  (db_wr),
        .db_rd  (db_rd)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    typedef struct {
        int cyc;
        bit p;
        bit q;
    } exp_t;

    exp_t sbq[$];

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endfunction

    // Reference model: a button's debounced level flips once the
    // synchronised input has disagreed with it for DB+1 samples in a row.
    bit m_s1[2];
    bit m_s2[2];
    bit m_db[2];
    bit m_tk[2];
    int m_run[2];
    bit m_err;

    always @(posedge clk) begin : model
        bit b[2];
        bit s;
        bit rd_ok;
        bit wr_ok;
        bit rej;
        cyc_n++;
        b[0] = btn_wr;
        b[1] = btn_rd;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i]  = 0;
                m_s2[i]  = 0;
                m_db[i]  = 0;
                m_tk[i]  = 0;
                m_run[i] = 0;
            end
            m_err = 0;
        end else begin
            rd_ok = m_tk[1] && !empty;
            wr_ok = m_tk[0] && (!full || rd_ok);
            rej   = (m_tk[0] && !wr_ok) || (m_tk[1] && !rd_ok);
            if (rej) m_err = 1;
            else if (wr_ok || rd_ok) m_err = 0;
            if (wr_ok || rd_ok) sbq.push_back('{cyc_n, wr_ok, rd_ok});
            for (int i = 0; i < 2; i++) begin
                s       = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = b[i];
                m_tk[i] = 0;
                if (s != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_db[i]  = s;
                        m_run[i] = 0;
                        m_tk[i]  = s;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    // Monitor: compare strobes against the scoreboard, levels every cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc_n) begin
            e = sbq.pop_front();
            chk("missed_strobe", 0, 1);
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc_n) begin
            e = sbq.pop_front();
            chk("sb_push", int'(push), int'(e.p));
            chk("sb_pop", int'(pop), int'(e.q));
        end else if (push || pop) begin
            chk("unexpected_strobe", int'({push, pop}), 0);
        end
        chk("mon_error", int'(error), int'(m_err));
        chk("mon_db_wr", int'(db_wr), int'(m_db[0]));
        chk("mon_db_rd", int'(db_rd), int'(m_db[1]));
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit w, input bit r,
                         output int np, output int nq, output int nb);
        np = 0;
        nq = 0;
        nb = 0;
        btn_wr = w;
        btn_rd = r;
        repeat (DB + 6) begin
            cyc(1);
            np += int'(push);
            nq += int'(pop);
            nb += int'(push && pop);
        end
    endtask

    task automatic release_all();
        btn_wr = 1'b0;
        btn_rd = 1'b0;
        cyc(DB + 6);
    endtask

    initial begin : stim
        int np;
        int nq;
        int nb;
        int pat;
        int dbh;
        int len[2];
        bit lvl[2];

        // reset state
        cyc(3);
        chk("rst_push", int'(push), 0);
        chk("rst_pop", int'(pop), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_db_wr", int'(db_wr), 0);
        chk("rst_db_rd", int'(db_rd), 0);
        reset = 1'b0;
        cyc(2);

        // clean held press: one push, 19 cycles after first high sample
        full   = 1'b0;
        empty  = 1'b0;
        btn_wr = 1'b1;
        np  = 0;
        pat = -1;
        for (int i = 1; i <= 45; i++) begin
            cyc(1);
            if (push) begin
                np++;
                if (pat < 0) pat = i;
            end
        end
        chk("t1_push_count", np, 1);
        chk("t1_push_latency", pat - 1, 19);
        chk("t1_db_wr", int'(db_wr), 1);
        chk("t1_error", int'(error), 0);
        release_all();
        chk("t1_db_wr_released", int'(db_wr), 0);

        // bouncing button: 3-cycle toggles never qualify
        np  = 0;
        dbh = 0;
        for (int i = 0; i < 10; i++) begin
            btn_wr = (i % 2 == 0);
            repeat (3) begin
                cyc(1);
                np  += int'(push);
                dbh += int'(db_wr);
            end
        end
        release_all();
        chk("t2_push_count", np, 0);
        chk("t2_db_high", dbh, 0);

        // write at full is rejected, then accepted once not full
        full = 1'b1;
        press(1, 0, np, nq, nb);
        chk("t3_push_full", np, 0);
        chk("t3_error_set", int'(error), 1);
        release_all();
        full = 1'b0;
        press(1, 0, np, nq, nb);
        chk("t3_push_ok", np, 1);
        chk("t3_error_clr", int'(error), 0);
        release_all();

        // read at empty is rejected, then accepted once not empty
        empty = 1'b1;
        press(0, 1, np, nq, nb);
        chk("t4_pop_empty", nq, 0);
        chk("t4_error_set", int'(error), 1);
        release_all();
        empty = 1'b0;
        press(0, 1, np, nq, nb);
        chk("t4_pop_ok", nq, 1);
        chk("t4_error_clr", int'(error), 0);
        release_all();

        // simultaneous read and write at full
        full  = 1'b1;
        empty = 1'b0;
        press(1, 1, np, nq, nb);
        chk("t5_both_same_cycle", nb, 1);
        chk("t5_push_count", np, 1);
        chk("t5_error", int'(error), 0);
        release_all();
        full = 1'b0;

        // reset during the 10th WAIT1 cycle aborts the press
        btn_wr = 1'b1;
        np = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            np += int'(push);
        end
        reset = 1'b1;
        cyc(1);
        np += int'(push);
        reset = 1'b0;
        chk("t6_no_push_before_reset", np, 0);
        np  = 0;
        pat = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (push) begin
                np++;
                if (pat < 0) pat = i;
            end
        end
        chk("t6_push_count", np, 1);
        chk("t6_push_latency", pat - 1, 19);
        release_all();

        // random traffic: mix of short bounces and long holds
        for (int i = 0; i < 2; i++) begin
            lvl[i] = 0;
            len[i] = 1;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                len[i]--;
                if (len[i] <= 0) begin
                    lvl[i] = !lvl[i];
                    len[i] = int'($urandom_range(1, 2 * DB + 4));
                end
            end
            btn_wr = lvl[0];
            btn_rd = lvl[1];
            full   = ($urandom % 4 == 0);
            empty  = ($urandom % 4 == 0);
            reset  = ($urandom % 500 == 0);
            cyc(1);
        end
        reset = 1'b0;
        release_all();
        cyc(4);
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_btn_ctrl.md
Name: fifo_btn_ctrl

Overview:
- Upstream stage of the board-level FIFO demo. Sits between the raw wr/rd push-buttons and the FIFO's wr/rd inputs.
- Synchronises and debounces each button, then converts each debounced press into a single-cycle push/pop strobe.
- Gates each strobe against the FIFO's full/empty flags and raises an error flag on rejected requests.

Parameters:
- DB_CYCLES, 16, number of consecutive stable clock cycles required to accept a level change. Board builds override with 2^20.
- CNT_W, 21, width of each debounce counter. Must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock. Only clock domain.
- reset  input  1  synchronous, active-high reset.
- btn_wr  input  1  raw, asynchronous, bouncy write button.
- btn_rd  input  1  raw, asynchronous, bouncy read button.
- full  input  1  FIFO full flag.
- empty  input  1  FIFO empty flag.
- push  output  1  registered one-cycle write strobe to the FIFO.
- pop  output  1  registered one-cycle read strobe to the FIFO.
- error  output  1  registered sticky flag for a rejected request.
- db_wr  output  1  debounced level of btn_wr.
- db_rd  output  1  debounced level of btn_rd.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
  - In reset, every output is 0: push, pop, error, db_wr, db_rd.
  - In reset, both FSMs go to ZERO, counters to 0, synchroniser flops to 0.
  - A reset asserted mid-debounce or mid-strobe aborts that operation. No strobe is emitted for that operation.
- Synchroniser: each button passes through 2 flops. s_wr and s_rd are the second-flop outputs.
- Per-button FSM, identical for wr and rd:
  - ZERO: db=0, cnt=0. If s=1, go to WAIT1.
  - WAIT1: if s=0, go to ZERO with cnt=0. Otherwise cnt++. When cnt==DB_CYCLES-1 and s=1, go to ONE and assert the internal tick for one cycle.
  - ONE: db=1, cnt=0. If s=0, go to WAIT0.
  - WAIT0: if s=1, go to ONE with cnt=0. Otherwise cnt++. When cnt==DB_CYCLES-1, go to ZERO. No tick is generated on release.
- Level and latency:
  - db is 1 in ONE and WAIT0, 0 otherwise.
  - A clean press is sampled high at edge k. The tick is registered at edge k+2+DB_CYCLES. push/pop go high at edge k+3+DB_CYCLES and stay high for exactly 1 cycle.
  - A button held indefinitely produces exactly one strobe. A bounce shorter than DB_CYCLES produces none.
- Gating, evaluated on the tick cycle using the current full/empty:
  - Write is accepted if full=0, or if full=1 and a read is accepted in the same cycle (simultaneous read/write at full).
  - Read is accepted if empty=0. A read is never accepted at empty, even with a simultaneous write.
  - Simultaneous accepted ticks assert push and pop in the same cycle.
- error:
  - Set to 1 on the cycle after any rejected tick.
  - Cleared to 0 on the cycle after any accepted strobe, or by reset.
  - If one tick is accepted and the other rejected in the same cycle, error=1.
- Counters saturate logic-wise at DB_CYCLES-1 and never wrap.

Test Plan:
- Reset, then btn_wr=1 held for 45 cycles with DB_CYCLES=16 and full=0 → push=1 for exactly 1 cycle, 19 cycles after the first high sample; db_wr=1; error=0; no second push while held.
- btn_wr toggling 1/0 every 3 cycles for 30 cycles → push never asserted, db_wr stays 0, counters return to 0.
- full=1, btn_wr press → push stays 0, error=1 from the strobe slot onward. Then full=0, new press → push pulse, error=0 on the next cycle.
- empty=1, btn_rd press → pop=0, error=1. Then empty=0, btn_rd press → pop one cycle, error cleared.
- full=1, btn_wr and btn_rd rising on the same cycle → push=1 and pop=1 in the same cycle, error=0.
- reset pulsed at the 10th cycle of WAIT1 with btn_wr held → no push ever for that press. After reset release, the press must be re-qualified: push arrives 19 cycles after the post-reset high sample.
